// File: rtl/lut_neuron_array_if.sv
// Stream-side handshake bundle for lut_neuron_array: the input word channel
// (s_*) and the registered result channel (m_*).
interface lut_neuron_array_if #(
    parameter int NUM_NEURONS = 4,
    parameter int FANIN_BITS  = 6,
    parameter int OUT_BITS    = 2
) ();
    logic                              s_valid;
    logic                              s_ready;
    logic [NUM_NEURONS*FANIN_BITS-1:0] s_data;
    logic                              m_valid;
    logic                              m_ready;
    logic [NUM_NEURONS*OUT_BITS-1:0]   m_data;

    // Upstream producer / downstream consumer side
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

    // Neuron array side
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/lut_neuron_array.sv
// Runtime-programmable array of LUT neurons. Each neuron maps its FANIN_BITS
// input slice through a private OUT_BITS-wide truth table; all results of an
// accepted word are registered together behind a valid/ready output stage.
// Tables are zero-filled by a self-clearing sequence after reset or cfg_clear.
module lut_neuron_array #(
    parameter  int NUM_NEURONS = 4,
    parameter  int FANIN_BITS  = 6,
    parameter  int OUT_BITS    = 2,
    localparam int NW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [NW-1:0]         cfg_neuron,
    input  logic [FANIN_BITS-1:0] cfg_addr,
    input  logic [OUT_BITS-1:0]   cfg_data,
    input  logic                  cfg_clear,
    output logic                  busy,
    lut_neuron_array_if.slave     io
);
    localparam int DEPTH = 1 << FANIN_BITS;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                          state;
    logic [FANIN_BITS-1:0]           clr_cnt;
    logic [OUT_BITS-1:0]             tbl [NUM_NEURONS][DEPTH];
    logic [NUM_NEURONS*OUT_BITS-1:0] lookup;
    logic                            accept;

    // Ready depends only on state and the output register, never on s_valid
    assign io.s_ready = (state == RUN) && (!io.m_valid || io.m_ready);
    assign accept     = io.s_valid && io.s_ready;

    // Combinational table read for every neuron; sees the pre-edge contents,
    // so a same-cycle cfg write to the addressed entry returns the old value
    always_comb begin
        lookup = '0;
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
            lookup[i*OUT_BITS +: OUT_BITS] = tbl[i][io.s_data[i*FANIN_BITS +: FANIN_BITS]];
        end
    end

    // Table write port: zero-fill while clearing, otherwise in-range cfg writes
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
            if (!rst && state == CLEAR) begin
                tbl[i][clr_cnt] <= '0;
            end else if (!rst && state == RUN && cfg_we && cfg_neuron == NW'(i)) begin
                tbl[i][cfg_addr] <= cfg_data;
            end
        end
    end

    // Clear/run FSM with registered busy, plus the output holding register,
    // which keeps draining independently of the FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            busy       <= 1'b1;
            io.m_valid <= 1'b0;
            io.m_data  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + FANIN_BITS'(1);
                    if (clr_cnt == '1) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (cfg_clear) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                    busy    <= 1'b1;
                end
            endcase

            if (accept) begin
                io.m_valid <= 1'b1;
                io.m_data  <= lookup;
            end else if (io.m_ready) begin
                io.m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lut_neuron_array.sv
// Self-checking bench for lut_neuron_array: table-driven lookup vectors,
// scoreboard on the output channel, and hand-written corner sequences.
module tb_lut_neuron_array;
    localparam int NN  = 4;
    localparam int FB  = 6;
    localparam int OB  = 2;
    localparam int NN2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cfg_we, cfg_clear, busy;
    logic [1:0] cfg_neuron;
    logic [5:0] cfg_addr;
    logic [1:0] cfg_data;

    logic       cfg_we2, cfg_clear2, busy2;
    logic [1:0] cfg_neuron2;
    logic [5:0] cfg_addr2;
    logic [1:0] cfg_data2;

    lut_neuron_array_if #(.NUM_NEURONS(NN), .FANIN_BITS(FB), .OUT_BITS(OB)) io ();
    lut_neuron_array_if #(.NUM_NEURONS(NN2), .FANIN_BITS(FB), .OUT_BITS(OB)) io2 ();

    lut_neuron_array #(.NUM_NEURONS(NN), .FANIN_BITS(FB), .OUT_BITS(OB)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_clear(cfg_clear),
        .busy(busy), .io(io.slave)
    );

    lut_neuron_array #(.NUM_NEURONS(NN2), .FANIN_BITS(FB), .OUT_BITS(OB)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we2), .cfg_neuron(cfg_neuron2),
        .cfg_addr(cfg_addr2), .cfg_data(cfg_data2), .cfg_clear(cfg_clear2),
        .busy(busy2), .io(io2.slave)
    );

    typedef struct {
        logic [23:0] sd;
        logic [7:0]  exp;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [1:0]  mdl [NN][64];
    logic [7:0]  sbq [$];
    logic        smp_mvalid, smp_sready, smp_busy;
    logic [7:0]  smp_mdata;
    int          busy_seen, ready_while_busy, pops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] mk(input logic [5:0] a0, input logic [5:0] a1,
                                       input logic [5:0] a2, input logic [5:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [7:0] model_lookup(input logic [23:0] sd);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < NN; i++) r[i*2 +: 2] = mdl[i][sd[i*6 +: 6]];
        return r;
    endfunction

    task automatic zero_model();
        for (int i = 0; i < NN; i++)
            for (int j = 0; j < 64; j++) mdl[i][j] = 2'b00;
    endtask

    // One clock: sample/score at negedge, then step past the rising edge
    task automatic cyc();
        logic [7:0] e;
        @(negedge clk);
        smp_mvalid = io.m_valid;
        smp_mdata  = io.m_data;
        smp_sready = io.s_ready;
        smp_busy   = busy;
        if (busy === 1'b1) begin
            busy_seen++;
            if (io.s_ready !== 1'b0) ready_while_busy++;
        end
        if (io.m_valid === 1'b1 && io.m_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                pops++;
                chk("sb_data", io.m_data, e);
            end
        end
        if (io.s_valid === 1'b1 && io.s_ready === 1'b1) sbq.push_back(model_lookup(io.s_data));
        if (cfg_we && !rst && cfg_neuron < NN) mdl[cfg_neuron][cfg_addr] = cfg_data;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] n, input logic [5:0] a, input logic [1:0] d);
        cfg_we = 1'b1; cfg_neuron = n; cfg_addr = a; cfg_data = d;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (smp_busy === 1'b1 && n < 300);
        chk({name, "_busy_cycles"}, busy_seen, 64);
        chk({name, "_ready_in_clear"}, ready_while_busy, 0);
    endtask

    task automatic drain();
        io.s_valid = 1'b0;
        io.m_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (sbq.size() == 0) break;
            cyc();
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    task automatic send_random(input int cnt);
        io.m_ready = 1'b1;
        for (int k = 0; k < cnt; k++) begin
            io.s_valid = 1'b1;
            io.s_data  = 24'($urandom);
            cyc();
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [6];
        logic [5:0]  pool [5];
        logic [23:0] words [8];
        logic [7:0]  held;
        int          idx, stall_left, pops0, guard;

        rst = 1'b1;
        cfg_we = 1'b0; cfg_clear = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
        cfg_we2 = 1'b0; cfg_clear2 = 1'b0; cfg_neuron2 = '0; cfg_addr2 = '0; cfg_data2 = '0;
        io.s_valid = 1'b0; io.s_data = '0; io.m_ready = 1'b1;
        io2.s_valid = 1'b0; io2.s_data = '0; io2.m_ready = 1'b1;
        pops = 0;
        zero_model();

        // Reset values
        cyc();
        cyc();
        chk("rst_busy", smp_busy, 1);
        chk("rst_sready", smp_sready, 0);
        chk("rst_mvalid", smp_mvalid, 0);
        chk("rst_mdata", smp_mdata, 0);
        chk("rst_busy2", busy2, 1);

        // Post-reset clear: exactly 64 busy cycles, then all-zero lookups
        rst = 1'b0;
        busy_seen = 0; ready_while_busy = 0;
        wait_clear("reset");
        chk("reset_busy_low", busy, 0);
        send_random(6);

        // Out-of-range write on a 3-neuron array leaves every table untouched
        cfg_we2 = 1'b1; cfg_neuron2 = 2'd3; cfg_addr2 = 6'd10; cfg_data2 = 2'b11;
        cyc();
        cfg_neuron2 = 2'd2; cfg_addr2 = 6'd11; cfg_data2 = 2'b10;
        cyc();
        cfg_we2 = 1'b0;
        io2.s_valid = 1'b1; io2.s_data = {6'd10, 6'd10, 6'd10};
        cyc();
        chk("oor_valid", io2.m_valid, 1);
        chk("oor_no_write", io2.m_data, 6'h00);
        io2.s_data = {6'd11, 6'd11, 6'd11};
        cyc();
        chk("oor_legal_write", io2.m_data, 6'h20);
        io2.s_valid = 1'b0;

        // Program tables and run the lookup vector table
        wr(2'd0, 6'd32, 2'b01);
        wr(2'd3, 6'd63, 2'b10);
        wr(2'd1, 6'd5,  2'b11);
        wr(2'd2, 6'd7,  2'b11);
        vecs[0] = '{mk(6'd32, 6'd0, 6'd0, 6'd63), 8'h81};
        vecs[1] = '{mk(6'd0,  6'd0, 6'd0, 6'd0),  8'h00};
        vecs[2] = '{mk(6'd0,  6'd5, 6'd7, 6'd0),  8'h3C};
        vecs[3] = '{mk(6'd32, 6'd5, 6'd7, 6'd63), 8'hBD};
        vecs[4] = '{mk(6'd63, 6'd0, 6'd0, 6'd32), 8'h00};
        vecs[5] = '{mk(6'd32, 6'd32, 6'd32, 6'd32), 8'h01};
        io.m_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            io.s_valid = 1'b1;
            io.s_data  = vecs[v].sd;
            cyc();
            chk($sformatf("vec%0d_valid", v), io.m_valid, 1);
            chk($sformatf("vec%0d_data", v), io.m_data, vecs[v].exp);
        end
        drain();

        // Same-cycle write and lookup of one entry: old value first, new after
        cfg_we = 1'b1; cfg_neuron = 2'd1; cfg_addr = 6'd5; cfg_data = 2'b01;
        io.s_valid = 1'b1; io.s_data = mk(6'd0, 6'd5, 6'd0, 6'd0);
        cyc();
        cfg_we = 1'b0;
        chk("collide_old", io.m_data, 8'h0C);
        cyc();
        chk("collide_new", io.m_data, 8'h04);
        drain();

        // Backpressure: 8 words, m_ready low for 5 cycles after first accept
        pool = '{6'd0, 6'd32, 6'd63, 6'd5, 6'd7};
        for (int k = 0; k < 8; k++)
            words[k] = mk(pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)],
                          pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)]);
        idx = 0; stall_left = -1; pops0 = pops; guard = 0; held = '0;
        while (pops - pops0 < 8 && guard < 60) begin
            guard++;
            io.s_valid = (idx < 8);
            if (idx < 8) io.s_data = words[idx];
            io.m_ready = !(stall_left > 0);
            cyc();
            if (!io.m_ready) begin
                chk("bp_sready", smp_sready, 0);
                chk("bp_mvalid", smp_mvalid, 1);
                if (stall_left == 5) held = smp_mdata;
                else chk("bp_hold", smp_mdata, held);
                stall_left--;
            end
            if (io.s_valid && smp_sready === 1'b1) begin
                idx++;
                if (stall_left < 0) stall_left = 5;
            end
        end
        chk("bp_count", pops - pops0, 8);
        drain();

        // Clear while a word is held: word survives, inputs stall, then zeros
        io.m_ready = 1'b0; io.s_valid = 1'b1; io.s_data = mk(6'd32, 6'd0, 6'd0, 6'd0);
        cyc();
        io.s_valid = 1'b0; cfg_clear = 1'b1;
        cyc();
        cfg_clear = 1'b0;
        zero_model();
        busy_seen = 0; ready_while_busy = 0;
        io.s_valid = 1'b1; io.s_data = mk(6'd32, 6'd5, 6'd7, 6'd63);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("clr_hold_valid", smp_mvalid, 1);
            chk("clr_hold_data", smp_mdata, 8'h01);
            chk("clr_busy", smp_busy, 1);
        end
        io.m_ready = 1'b1;
        wait_clear("clear");
        drain();
        send_random(6);

        // Reset while a word is held drops m_valid and restarts the clear
        wr(2'd2, 6'd9, 2'b11);
        io.m_ready = 1'b0; io.s_valid = 1'b1; io.s_data = mk(6'd0, 6'd0, 6'd9, 6'd0);
        cyc();
        chk("midrst_pre_data", io.m_data, 8'h30);
        io.s_valid = 1'b0;
        rst = 1'b1;
        cyc();
        chk("midrst_mvalid", io.m_valid, 0);
        chk("midrst_busy", busy, 1);
        sbq.delete();
        zero_model();
        rst = 1'b0;
        busy_seen = 0; ready_while_busy = 0;
        io.m_ready = 1'b1;
        wait_clear("midrst");
        io.s_valid = 1'b1; io.s_data = mk(6'd0, 6'd0, 6'd9, 6'd0);
        cyc();
        chk("midrst_zero", io.m_data, 8'h00);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lut_neuron_array.md
# lut_neuron_array

Parametrised, runtime-programmable array of LUT neurons: each of NUM_NEURONS neurons maps a FANIN_BITS-wide input slice to an OUT_BITS-wide output through its own truth table held in distributed RAM. It replaces fixed per-neuron case-statement ROMs, so one layer netlist can be reprogrammed with new trained tables without resynthesis. The block sits between layers of the classifier datapath and adds a registered output stage with a valid/ready handshake. It also provides a self-clearing table FSM.

## Interface
- NUM_NEURONS, 4: neurons in the array.
- FANIN_BITS, 6: input bits per neuron; table depth = 2^FANIN_BITS.
- OUT_BITS, 2: output bits per neuron.
- NW = max(1, clog2(NUM_NEURONS)): local width, not overridable.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_neuron  in  NW  target neuron for the write.
- cfg_addr  in  FANIN_BITS  table entry.
- cfg_data  in  OUT_BITS  entry value.
- cfg_clear  in  1  one-cycle pulse that starts a zero-fill of all tables.
- busy  out  1  high while clearing.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid && s_ready.
- s_data  in  NUM_NEURONS*FANIN_BITS  neuron i's address = s_data[i*FANIN_BITS +: FANIN_BITS], unsigned.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  NUM_NEURONS*OUT_BITS  neuron i's result at m_data[i*OUT_BITS +: OUT_BITS].

## Operation
- FSM states: CLEAR and RUN.
- Reset enters CLEAR with clear counter = 0. cfg_clear asserted in RUN also enters CLEAR with counter = 0.
- CLEAR: each cycle, write 0 to entry[counter] of every neuron, then increment the counter. After writing entry 2^FANIN_BITS-1, go to RUN on the next edge. A clear takes exactly 2^FANIN_BITS cycles.
- In CLEAR: busy=1, s_ready=0, cfg_we ignored, cfg_clear ignored. The m_valid/m_data holding register keeps draining normally.
- RUN: busy=0.
  - cfg_we writes cfg_data into table[cfg_neuron][cfg_addr] at the edge.
  - A cfg_neuron value >= NUM_NEURONS is ignored, with no write.
- Lookup in RUN: on an accepted input, every neuron reads its table combinationally, and all results are registered into m_data with m_valid=1.
- Read-before-write: a lookup and a cfg write to the same entry in the same cycle return the OLD value. The new value is visible to inputs accepted on later cycles.
- s_ready = (state==RUN) && (!m_valid || m_ready). This gives full throughput of one word per cycle with no bubble.
- Output register:
  - Loads on accept.
  - Clears m_valid on m_valid && m_ready without a new accept.
  - Holds m_data and m_valid stable while m_valid && !m_ready.
- Table contents are not reset directly; they are defined only through the post-reset clear.

## Timing
- Reset values:
  - state=CLEAR, counter=0, busy=1, s_ready=0, m_valid=0, m_data=0.
  - After rst deasserts, busy stays 1 for 2^FANIN_BITS cycles (64 at defaults), then drops.
- Latency: input accepted at edge k gives m_valid=1 and valid m_data after edge k, i.e. 1 cycle.
- Simultaneous m_ready and new accept in the same cycle: the output is replaced, and m_valid stays 1.
- cfg_clear while m_valid && !m_ready: the held word is preserved until consumed. Subsequent inputs stall until RUN.
- rst mid-clear or mid-transfer restarts the clear from counter 0 and drops m_valid the same edge.
- No combinational path exists from s_valid to s_ready, or from m_ready to m_data.

## Test plan
- Reset/clear:
  - Stimulus: assert rst 2 cycles, release.
  - Required: busy=1 and s_ready=0 for exactly 64 cycles, then busy=0; every lookup at any address returns m_data=0.
- Program and lookup:
  - Stimulus: write neuron0 entry 6'b100000=2'b01 and neuron3 entry 6'b111111=2'b10, then send s_data with slice0=6'b100000 and slice3=6'b111111, others 0.
  - Required: one cycle later m_valid=1, m_data[1:0]=01, m_data[7:6]=10, other fields 00.
- Backpressure:
  - Stimulus: stream 8 words with m_ready held 0 for 5 cycles after the first accept.
  - Required: m_data constant and s_ready=0 throughout the stall; all 8 results arrive in order, none dropped or duplicated.
- Write/read collision:
  - Stimulus: entry 5 of neuron1 holds 11; in the same cycle write 01 to it and accept an input addressing it.
  - Required: the output is 11; the next lookup returns 01.
- Clear during traffic:
  - Stimulus: pulse cfg_clear while a word is held with m_ready=0, then set m_ready=1.
  - Required: the held word is delivered intact; busy=1 for 64 cycles; afterwards all lookups return 0.
- Out-of-range write:
  - Stimulus: at NUM_NEURONS=3, cfg_neuron=3.
  - Required: no table changes.
